// File: rtl/ecc_modalu_if.sv
// ALU command/result bundle between the ECDSA r/s/inverse sequencer and ecc_modalu.
// The sequencer is the master; ecc_modalu is the slave.
interface ecc_modalu_if #(
    parameter int WID = 256
) ();
    logic           aen;
    logic [1:0]     aop;
    logic [WID-1:0] ramrd;
    logic [WID-1:0] adi;
    logic           adivld;
    logic           busy;
    logic           cmderr;

    modport master (output aen, aop, ramrd, input adi, adivld, busy, cmderr);
    modport slave  (input aen, aop, ramrd, output adi, adivld, busy, cmderr);
endinterface

// File: rtl/ecc_modalu.sv
// Modular add / multiply / inverse responder for the ECDSA ALU port.
// Operands come from the RAM read port on the two cycles after a command; the result is registered.
module ecc_modalu #(
    parameter int             WID  = 256,
    parameter logic [WID-1:0] MODN = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141
) (
    input  logic         clk,
    input  logic         rst_n,
    ecc_modalu_if.slave  bus
);
    localparam int             IDXW = $clog2(WID);
    localparam logic [WID-1:0] ONE  = WID'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDA  = 3'd1;
    localparam logic [2:0] S_LDB  = 3'd2;
    localparam logic [2:0] S_CALC = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic [1:0] OP_FA  = 2'b00;
    localparam logic [1:0] OP_MUL = 2'b01;
    localparam logic [1:0] OP_INV = 2'b10;

    logic [2:0]     r_state;
    logic [1:0]     r_op;
    logic [WID-1:0] r_opa, r_opb;
    logic [WID-1:0] r_acc;             // MUL accumulator, reused as u for INV
    logic [WID-1:0] r_v, r_x1, r_x2;
    logic [7:0]     r_idx;
    logic [WID-1:0] r_adi;
    logic           r_adivld;
    logic           r_cmderr;

    logic           w_fin;
    logic [WID-1:0] w_res, w_dbl, w_acc_nx, w_v_nx, w_x1_nx, w_x2_nx;

    function automatic logic [WID-1:0] add_mod(input logic [WID-1:0] a, input logic [WID-1:0] b);
        logic [WID:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, MODN})
            s = s - {1'b0, MODN};
        return s[WID-1:0];
    endfunction

    function automatic logic [WID-1:0] sub_mod(input logic [WID-1:0] a, input logic [WID-1:0] b);
        return (a >= b) ? (a - b) : (a - b + MODN);
    endfunction

    function automatic logic [WID-1:0] half_mod(input logic [WID-1:0] x);
        logic [WID:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, MODN}) : {1'b0, x};
        return s[WID:1];
    endfunction

    // Each INV step fuses the subtraction with the halving it always enables (u-v of two odds
    // is even), keeping the step count within 2*WID while producing the same result.
    always_comb begin
        w_fin    = 1'b1;
        w_res    = '0;
        w_dbl    = add_mod(r_acc, r_acc);
        w_acc_nx = r_acc;
        w_v_nx   = r_v;
        w_x1_nx  = r_x1;
        w_x2_nx  = r_x2;
        case (r_op)
            OP_FA: w_res = add_mod(r_opa, r_opb);
            OP_MUL: begin
                w_acc_nx = add_mod(w_dbl, r_opb[r_idx[IDXW-1:0]] ? r_opa : '0);
                w_res    = w_acc_nx;
                w_fin    = (r_idx == 8'd0);
            end
            OP_INV: begin
                if (r_acc == '0) begin
                    w_res = '0;
                end else if (r_acc == ONE) begin
                    w_res = r_x1;
                end else if (r_v == ONE) begin
                    w_res = r_x2;
                end else begin
                    w_fin = 1'b0;
                    if (!r_acc[0]) begin
                        w_acc_nx = r_acc >> 1;
                        w_x1_nx  = half_mod(r_x1);
                    end else if (!r_v[0]) begin
                        w_v_nx  = r_v >> 1;
                        w_x2_nx = half_mod(r_x2);
                    end else if (r_acc >= r_v) begin
                        w_acc_nx = (r_acc - r_v) >> 1;
                        w_x1_nx  = half_mod(sub_mod(r_x1, r_x2));
                    end else begin
                        w_v_nx  = (r_v - r_acc) >> 1;
                        w_x2_nx = half_mod(sub_mod(r_x2, r_x1));
                    end
                end
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_adi    <= '0;
            r_adivld <= 1'b0;
            r_cmderr <= 1'b0;
        end else begin
            r_adivld <= 1'b0;
            r_cmderr <= bus.aen && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: if (bus.aen) r_state <= S_LDA;
                S_LDA:  r_state <= S_LDB;
                S_LDB:  r_state <= S_CALC;
                S_CALC: begin
                    if (w_fin) begin
                        r_adi    <= w_res;
                        r_adivld <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Operand and iteration registers carry no reset; IDLE never looks at them.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: if (bus.aen) r_op <= bus.aop;
            S_LDA:  r_opa <= bus.ramrd;
            S_LDB: begin
                r_opb <= bus.ramrd;
                r_acc <= (r_op == OP_INV) ? r_opa : '0;
                r_v   <= MODN;
                r_x1  <= ONE;
                r_x2  <= '0;
                r_idx <= 8'(WID - 1);
            end
            S_CALC: begin
                r_acc <= w_acc_nx;
                r_v   <= w_v_nx;
                r_x1  <= w_x1_nx;
                r_x2  <= w_x2_nx;
                r_idx <= r_idx - 8'd1;
            end
            default: ;
        endcase
    end

    assign bus.adi    = r_adi;
    assign bus.adivld = r_adivld;
    assign bus.busy   = (r_state != S_IDLE);
    assign bus.cmderr = r_cmderr;
endmodule

// File: tb/tb_ecc_modalu.sv
// Scoreboard bench for ecc_modalu: an 8-bit/251 instance for directed cases and a
// default-width instance driven through an ECDSA s = k^-1*(h+r*d) mod n sequence.
module tb_ecc_modalu;
    localparam logic [255:0] N256 = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ecc_modalu_if #(.WID(8))   b8 ();
    ecc_modalu_if #(.WID(256)) b256 ();

    ecc_modalu #(.WID(8), .MODN(8'd251)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    ecc_modalu #(.WID(256), .MODN(N256)) u_dut256 (.clk(clk), .rst_n(rst_n), .bus(b256));

    typedef struct {
        logic [255:0] exp;
        int           t0;
        int           minl;
        int           maxl;
        string        name;
    } exp_t;

    exp_t q8[$];
    exp_t q256[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;
    int   cerr8  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endfunction

    // Reference arithmetic for the wide instance, via plain % on double-width products.
    function automatic logic [255:0] mmul(input logic [255:0] a, input logic [255:0] b);
        logic [511:0] p;
        p = {256'b0, a} * {256'b0, b};
        p = p % {256'b0, N256};
        return p[255:0];
    endfunction

    function automatic logic [255:0] madd(input logic [255:0] a, input logic [255:0] b);
        logic [256:0] s;
        s = {1'b0, a} + {1'b0, b};
        s = s % {1'b0, N256};
        return s[255:0];
    endfunction

    function automatic logic [255:0] minv(input logic [255:0] a);
        logic [255:0] e, r, base;
        e = N256 - 256'd2;
        r = 256'd1;
        base = a;
        for (int i = 0; i < 256; i++) begin
            if (e[i]) r = mmul(r, base);
            base = mmul(base, base);
        end
        return r;
    endfunction

    function automatic int inv8(input int a);
        for (int x = 1; x < 251; x++)
            if ((x * a) % 251 == 1) return x;
        return 0;
    endfunction

    task automatic mon_one(input bit wide, input logic [255:0] act);
        exp_t e;
        int   lat;
        if ((wide && q256.size() == 0) || (!wide && q8.size() == 0)) begin
            chk(1'b0, "unexpected adivld", act, 256'd0);
            return;
        end
        if (wide) e = q256.pop_front();
        else      e = q8.pop_front();
        lat = cyc + 1 - e.t0;
        chk(act == e.exp, e.name, act, e.exp);
        chk(lat >= e.minl && lat <= e.maxl, {e.name, " latency"}, 256'(lat), 256'(e.maxl));
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (b8.cmderr) cerr8++;
            if (b8.adivld) mon_one(1'b0, 256'(b8.adi));
            if (b256.adivld) mon_one(1'b1, b256.adi);
        end
    end

    task automatic issue(input bit wide, input logic [1:0] op, input logic [255:0] a, input logic [255:0] b,
                         input logic [255:0] ex, input int minl, input int maxl, input string name, input bit poke);
        exp_t e;
        if (wide) begin b256.aen = 1'b1; b256.aop = op; end
        else      begin b8.aen = 1'b1;   b8.aop = op;   end
        @(posedge clk); #1;
        e.exp = ex; e.t0 = cyc; e.minl = minl; e.maxl = maxl; e.name = name;
        if (wide) begin q256.push_back(e); b256.aen = 1'b0; b256.ramrd = a; end
        else      begin q8.push_back(e);   b8.aen = 1'b0;   b8.ramrd = a[7:0]; end
        @(posedge clk); #1;
        if (wide) b256.ramrd = b;
        else begin
            b8.ramrd = b[7:0];
            if (poke) begin b8.aen = 1'b1; b8.aop = 2'b01; end
        end
        @(posedge clk); #1;
        b8.aen = 1'b0;
        if (wide) b256.ramrd = ~b;
        else      b8.ramrd = 8'hA5;
    endtask

    task automatic issue8(input logic [1:0] op, input int a, input int b, input int ex,
                          input int minl, input int maxl, input string name);
        issue(1'b0, op, 256'(a), 256'(b), 256'(ex), minl, maxl, name, 1'b0);
    endtask

    task automatic wait_done(input bit wide, input int budget);
        int n;
        for (int i = 0; i < budget; i++) begin
            n = wide ? q256.size() : q8.size();
            if (n == 0) break;
            @(posedge clk);
        end
        #1;
        n = wide ? q256.size() : q8.size();
        chk(n == 0, "completion within budget", 256'(n), 256'd0);
        if (wide) q256.delete();
        else      q8.delete();
    endtask

    logic [255:0] kv [3] = '{256'h1f3a5c7e9b2d4f6081a3c5e7092b4d6f8e1c3a5b7d9f0e2c4a6b8d0f1e3c5a79,
                             256'h7c2e4a6b8d0f1e3c5a7990b1c2d3e4f5061728394a5b6c7d8e9f0a1b2c3d4e5f,
                             256'h0000000000000000000000000000000000000000000000000000000000000003};
    logic [255:0] hv [3] = '{256'h5a5a5a5a0123456789abcdef0fedcba9876543210a1b2c3d4e5f60718293a4b5,
                             256'hfffffffffffffffffffffffffffffffebaaedce6af48a03bbfd25e8cd0364140,
                             256'h2468ace013579bdf2468ace013579bdf2468ace013579bdf2468ace013579bdf};
    logic [255:0] rv [3] = '{256'h3b1f00d2c4e6a8b9d0e1f2031425364758697a8b9cadbecfd0e1f20314253647,
                             256'h123456789abcdef00fedcba987654321123456789abcdef00fedcba987654321,
                             256'hdeadbeefcafebabe0011223344556677889900aabbccddeeff00112233445566};
    logic [255:0] dv [3] = '{256'h6e5d4c3b2a19087f6e5d4c3b2a19087f6e5d4c3b2a19087f6e5d4c3b2a19087f,
                             256'h0f0e0d0c0b0a09080706050403020100f0e0d0c0b0a090807060504030201000,
                             256'h9876543210fedcba9876543210fedcba9876543210fedcba9876543210fedcba};

    initial begin
        int c0;
        logic [255:0] kinv, t1, t2, s;
        b8.aen = 1'b0;   b8.aop = 2'b00;   b8.ramrd = '0;
        b256.aen = 1'b0; b256.aop = 2'b00; b256.ramrd = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(b8.adi == 8'd0, "reset adi", 256'(b8.adi), 256'd0);
        chk(b8.adivld == 1'b0, "reset adivld", 256'(b8.adivld), 256'd0);
        chk(b8.busy == 1'b0, "reset busy", 256'(b8.busy), 256'd0);
        chk(b8.cmderr == 1'b0, "reset cmderr", 256'(b8.cmderr), 256'd0);
        chk(b256.adi == 256'd0, "reset adi wide", b256.adi, 256'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue8(2'b00, 200, 100, 49, 4, 4, "FA 200+100");   wait_done(1'b0, 40);
        issue8(2'b01, 17, 15, 4, 11, 11, "MUL 17*15");     wait_done(1'b0, 40);
        issue8(2'b01, 250, 250, 1, 11, 11, "MUL 250*250"); wait_done(1'b0, 40);
        issue8(2'b01, 0, 37, 0, 11, 11, "MUL 0*37");       wait_done(1'b0, 40);
        issue8(2'b10, 3, 99, 84, 4, 19, "INV 3");          wait_done(1'b0, 40);
        issue8(2'b10, 1, 7, 1, 4, 19, "INV 1");            wait_done(1'b0, 40);
        issue8(2'b10, 250, 0, 250, 4, 19, "INV 250");      wait_done(1'b0, 40);
        issue8(2'b10, 0, 5, 0, 4, 4, "INV 0");             wait_done(1'b0, 40);
        issue8(2'b11, 5, 6, 0, 4, 4, "reserved op");       wait_done(1'b0, 40);

        for (int a = 1; a < 251; a++) begin
            issue8(2'b10, a, 0, inv8(a), 4, 19, $sformatf("INV sweep a=%0d", a));
            wait_done(1'b0, 40);
        end

        // Command during LDB, another in the adivld cycle, then a back-to-back accept.
        c0 = cerr8;
        issue(1'b0, 2'b00, 256'd200, 256'd100, 256'd49, 4, 4, "FA with busy aen", 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b8.adivld) break;
        end
        b8.aen = 1'b1; b8.aop = 2'b10;
        @(posedge clk); #1;
        issue8(2'b00, 7, 9, 16, 4, 4, "FA back-to-back");
        wait_done(1'b0, 40);
        chk(cerr8 - c0 == 2, "cmderr pulse count", 256'(cerr8 - c0), 256'd2);

        // Reset while MUL is iterating.
        issue8(2'b01, 17, 15, 4, 11, 11, "MUL aborted");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        q8.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk(b8.busy == 1'b0, "busy after mid-op reset", 256'(b8.busy), 256'd0);
        chk(b8.adi == 8'd0, "adi after mid-op reset", 256'(b8.adi), 256'd0);
        repeat (15) @(posedge clk);
        #1;
        chk(b8.busy == 1'b0, "busy stays low", 256'(b8.busy), 256'd0);
        chk(b8.adi == 8'd0, "adi stays 0", 256'(b8.adi), 256'd0);
        issue8(2'b00, 1, 1, 2, 4, 4, "FA 1+1 after reset");
        wait_done(1'b0, 40);

        for (int v = 0; v < 3; v++) begin
            kinv = minv(kv[v]);
            t1   = mmul(rv[v], dv[v]);
            t2   = madd(hv[v], t1);
            s    = mmul(kinv, t2);
            issue(1'b1, 2'b10, kv[v], 256'd0, kinv, 4, 3 + 512, $sformatf("k^-1 vec%0d", v), 1'b0);
            wait_done(1'b1, 600);
            issue(1'b1, 2'b01, rv[v], dv[v], t1, 259, 259, $sformatf("r*d vec%0d", v), 1'b0);
            wait_done(1'b1, 300);
            issue(1'b1, 2'b00, hv[v], t1, t2, 4, 4, $sformatf("h+rd vec%0d", v), 1'b0);
            wait_done(1'b1, 40);
            issue(1'b1, 2'b01, kinv, t2, s, 259, 259, $sformatf("s vec%0d", v), 1'b0);
            wait_done(1'b1, 300);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
